// File: rtl/cam_config_sequencer.sv
// Camera sensor configuration sequencer: writes the register table to the sensor
// through the I2C master's request/ack port after power-up, soft reset or a setting change.
//
// state   | meaning
// STARTUP | post-reset settle delay
// IDLE    | waiting for pending_full or dirty with soft reset released
// REQ     | load address/data for the current table index
// WAIT    | wr_req held until wr_ack/wr_err
// GAP     | inter-transaction idle time
// DONE    | sequence finished cleanly
module cam_config_sequencer #(
  parameter logic [15:0] STARTUP_CYCLES  = 16'd50000,
  parameter logic [7:0]  GAP_CYCLES      = 8'd16,
  parameter logic [1:0]  MAX_RETRY       = 2'd2,
  parameter logic [7:0]  ADDR_SOFT_RESET = 8'h0D
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cfg_start_row,
  input  logic [15:0] cfg_start_column,
  input  logic [15:0] cfg_row_size,
  input  logic [15:0] cfg_column_size,
  input  logic [15:0] cfg_row_mode,
  input  logic [15:0] cfg_column_mode,
  input  logic [15:0] cfg_exposure,
  input  logic        cam_soft_reset_n,
  output logic        wr_req,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  input  logic        wr_ack,
  input  logic        wr_err,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error
);

  typedef enum logic [2:0] {
    ST_STARTUP, ST_IDLE, ST_REQ, ST_WAIT, ST_GAP, ST_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [111:0]  cfg_vec, shadow, shadow_nxt;
  logic [3:0]    idx, idx_nxt;
  logic [1:0]    retry, retry_nxt;
  logic [15:0]   cnt, cnt_nxt;
  logic          pending_full, pending_full_nxt;
  logic          dirty, dirty_nxt;
  logic          soft_q, soft_fall;
  logic          wr_req_nxt, busy_nxt, done_nxt, error_nxt;
  logic [7:0]    wr_addr_nxt, tbl_addr;
  logic [15:0]   wr_data_nxt, tbl_data;

  assign cfg_vec   = {cfg_start_row, cfg_start_column, cfg_row_size, cfg_column_size,
                      cfg_row_mode, cfg_column_mode, cfg_exposure};
  assign soft_fall = soft_q & ~cam_soft_reset_n;

  always_comb begin
    tbl_addr = ADDR_SOFT_RESET;
    tbl_data = 16'h0000;
    case (idx)
      4'd0: tbl_data = 16'h0001;
      4'd2: begin tbl_addr = 8'h01; tbl_data = shadow[111:96]; end
      4'd3: begin tbl_addr = 8'h02; tbl_data = shadow[95:80];  end
      4'd4: begin tbl_addr = 8'h03; tbl_data = shadow[79:64];  end
      4'd5: begin tbl_addr = 8'h04; tbl_data = shadow[63:48];  end
      4'd6: begin tbl_addr = 8'h22; tbl_data = shadow[47:32];  end
      4'd7: begin tbl_addr = 8'h23; tbl_data = shadow[31:16];  end
      4'd8: begin tbl_addr = 8'h09; tbl_data = shadow[15:0];   end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_STARTUP;
      shadow       <= '0;
      idx          <= '0;
      retry        <= '0;
      cnt          <= '0;
      pending_full <= 1'b1;
      dirty        <= 1'b0;
      soft_q       <= 1'b1;
      wr_req       <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      cfg_busy     <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_error    <= 1'b0;
    end else begin
      state        <= state_nxt;
      shadow       <= shadow_nxt;
      idx          <= idx_nxt;
      retry        <= retry_nxt;
      cnt          <= cnt_nxt;
      pending_full <= pending_full_nxt;
      dirty        <= dirty_nxt;
      soft_q       <= cam_soft_reset_n;
      wr_req       <= wr_req_nxt;
      wr_addr      <= wr_addr_nxt;
      wr_data      <= wr_data_nxt;
      cfg_busy     <= busy_nxt;
      cfg_done     <= done_nxt;
      cfg_error    <= error_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    shadow_nxt       = shadow;
    idx_nxt          = idx;
    retry_nxt        = retry;
    cnt_nxt          = cnt;
    pending_full_nxt = pending_full | soft_fall;
    dirty_nxt        = dirty | (cfg_vec != shadow);
    wr_req_nxt       = wr_req;
    wr_addr_nxt      = wr_addr;
    wr_data_nxt      = wr_data;
    busy_nxt         = cfg_busy;
    done_nxt         = cfg_done;
    error_nxt        = cfg_error;
    case (state)
      ST_STARTUP: begin
        if (cnt == STARTUP_CYCLES - 16'd1) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_IDLE: begin
        if (cam_soft_reset_n && (pending_full || dirty)) begin
          shadow_nxt       = cfg_vec;
          idx_nxt          = pending_full ? 4'd0 : 4'd2;
          pending_full_nxt = 1'b0;
          dirty_nxt        = 1'b0;
          retry_nxt        = '0;
          cnt_nxt          = '0;
          done_nxt         = 1'b0;
          error_nxt        = 1'b0;
          busy_nxt         = 1'b1;
          state_nxt        = ST_REQ;
        end
      end
      ST_REQ: begin
        // A soft reset seen since the last transaction abandons the sequence here.
        if (pending_full) begin
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          wr_req_nxt  = 1'b1;
          wr_addr_nxt = tbl_addr;
          wr_data_nxt = tbl_data;
          state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wr_err) begin
          wr_req_nxt = 1'b0;
          cnt_nxt    = '0;
          if (pending_full) begin
            retry_nxt = '0;
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end else if (retry < MAX_RETRY) begin
            retry_nxt = retry + 2'd1;
            state_nxt = ST_GAP;
          end else begin
            retry_nxt = '0;
            error_nxt = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end
        end else if (wr_ack) begin
          wr_req_nxt = 1'b0;
          retry_nxt  = '0;
          cnt_nxt    = '0;
          if (pending_full) begin
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = (idx == 4'd8) ? ST_DONE : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (pending_full) begin
          retry_nxt = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end else if (cnt == {8'd0, GAP_CYCLES} - 16'd1) begin
          cnt_nxt   = '0;
          idx_nxt   = (retry == 2'd0) ? idx + 4'd1 : idx;
          state_nxt = ST_REQ;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_STARTUP;
    endcase
  end

endmodule

// File: tb/tb_cam_config_sequencer.sv
// Directed + randomized bench for cam_config_sequencer; observed writes are compared
// with a queue-based model of the register table, retries and soft-reset behaviour.
module tb_cam_config_sequencer;
  localparam logic [15:0] STARTUP = 16'd10;
  localparam logic [7:0]  GAP     = 8'd4;
  localparam int          MAXR    = 2;
  localparam int          QUIET   = 16;

  logic        clk = 1'b0;
  logic        reset_n, soft_n;
  logic [15:0] cfg [7];
  logic        wr_req, wr_ack, wr_err, cfg_busy, cfg_done, cfg_error;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;

  logic [7:0]  field_addr [7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h22, 8'h23, 8'h09};
  logic [23:0] obs [$];
  logic [23:0] exp_q [$];
  int          obs_rd, checks, failures, err_used, err_budget, unstable, lat;
  logic [7:0]  err_addr;
  bit          hold_resp, spur;

  always #5 clk = ~clk;

  cam_config_sequencer #(.STARTUP_CYCLES(STARTUP), .GAP_CYCLES(GAP),
                         .MAX_RETRY(2'd2), .ADDR_SOFT_RESET(8'h0D)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_start_row(cfg[0]), .cfg_start_column(cfg[1]), .cfg_row_size(cfg[2]),
    .cfg_column_size(cfg[3]), .cfg_row_mode(cfg[4]), .cfg_column_mode(cfg[5]),
    .cfg_exposure(cfg[6]), .cam_soft_reset_n(soft_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error));

  // I2C master stand-in: random response delay, optional error injection and spurious pulses.
  initial begin
    int age, delay;
    wr_ack = 1'b0; wr_err = 1'b0; err_used = 0; age = 0; delay = 1;
    forever begin
      @(negedge clk);
      wr_ack = 1'b0; wr_err = 1'b0;
      if (wr_req && !hold_resp) begin
        if (age == 0) delay = int'($urandom_range(1, 4));
        age++;
        if (age >= delay) begin
          if (wr_addr == err_addr && err_used < err_budget) begin
            wr_err = 1'b1; err_used++;
          end else begin
            wr_ack = 1'b1;
          end
          age = 0;
        end
      end else if (!wr_req) begin
        age = 0;
        if (spur) begin
          if ($urandom_range(0, 1) == 1) wr_ack = 1'b1; else wr_err = 1'b1;
        end
      end
    end
  end

  // Transaction monitor: one entry per wr_req rising edge, plus a hold-stability count.
  initial begin
    logic        req_prev;
    logic [23:0] last;
    req_prev = 1'b0; last = '0; unstable = 0;
    forever begin
      @(negedge clk);
      if (wr_req && !req_prev) obs.push_back({wr_addr, wr_data});
      else if (wr_req && req_prev && {wr_addr, wr_data} != last) unstable++;
      if (wr_req) last = {wr_addr, wr_data};
      req_prev = wr_req;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic model_seq(input bit full, input int nerr);
    logic [23:0] ent [$];
    int att;
    if (full) begin
      ent.push_back({8'h0D, 16'h0001});
      ent.push_back({8'h0D, 16'h0000});
    end
    for (int k = 0; k < 7; k++) ent.push_back({field_addr[k], cfg[k]});
    foreach (ent[i]) begin
      att = (ent[i][23:16] == err_addr) ? nerr + 1 : 1;
      if (att > MAXR + 1) begin
        repeat (MAXR + 1) exp_q.push_back(ent[i]);
        return;
      end
      repeat (att) exp_q.push_back(ent[i]);
    end
  endtask

  task automatic check_writes(input string tag);
    int n;
    n = obs.size() - obs_rd;
    chk({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) chk({tag, "_write"}, obs[obs_rd + i], exp_q[i]);
    obs_rd = obs.size();
    exp_q.delete();
  endtask

  task automatic wait_quiet();
    int q, t;
    q = 0; t = 0;
    while (q < QUIET && t < 3000) begin
      @(negedge clk);
      t++;
      q = cfg_busy ? 0 : q + 1;
    end
    chk("quiet_timeout", q >= QUIET, 1);
  endtask

  task automatic wait_obs(input int n);
    int t;
    t = 0;
    while (obs.size() < obs_rd + n && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("obs_timeout", obs.size() >= obs_rd + n, 1);
  endtask

  task automatic measure_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_req && n < 500);
  endtask

  task automatic chk_flags(input string tag, input logic busy, input logic done, input logic err);
    chk({tag, "_busy"}, cfg_busy, busy);
    chk({tag, "_done"}, cfg_done, done);
    chk({tag, "_error"}, cfg_error, err);
  endtask

  initial begin
    reset_n = 1'b0; soft_n = 1'b1; hold_resp = 1'b0; spur = 1'b0;
    err_addr = 8'h03; err_budget = 0; obs_rd = 0; checks = 0; failures = 0;
    cfg = '{16'h0036, 16'h0010, 16'h059F, 16'h077F, 16'h0002, 16'h0002, 16'h07C0};
    repeat (3) @(negedge clk);
    chk("reset_wr_req", wr_req, 0);
    chk_flags("reset", 0, 0, 0);

    // Power-up full sequence
    reset_n = 1'b1;
    measure_start(lat);
    chk("startup_latency", lat, STARTUP + 2);
    model_seq(1, 0);
    wait_quiet();
    check_writes("powerup");
    chk_flags("powerup", 0, 1, 0);

    // Setting changes: directed exposure, then random fields
    cfg[6] = 16'h0400;
    model_seq(0, 0);
    wait_quiet();
    check_writes("exposure_change");
    chk_flags("exposure_change", 0, 1, 0);
    for (int r = 0; r < 4; r++) begin
      int f;
      logic [15:0] v;
      f = int'($urandom_range(0, 6));
      v = 16'($urandom);
      if (v == cfg[f]) v = ~v;
      cfg[f] = v;
      model_seq(0, 0);
      wait_quiet();
      check_writes("rand_change");
      chk("rand_change_done", cfg_done, 1);
    end

    // Change during the index-4 write: old shadow completes, then a rerun
    cfg[6] = cfg[6] ^ 16'h0101;
    model_seq(0, 0);
    wait_obs(4);
    cfg[0] = 16'h0040;
    model_seq(0, 0);
    wait_quiet();
    check_writes("change_mid_seq");
    chk_flags("change_mid_seq", 0, 1, 0);

    // Two errors on 0x03 then ack: retried with identical data
    cfg[2] = 16'($urandom) | 16'h8000;
    err_budget = err_used + 2;
    model_seq(0, 2);
    wait_quiet();
    check_writes("retry_ok");
    chk_flags("retry_ok", 0, 1, 0);

    // Three errors on 0x03: abort
    cfg[2] = cfg[2] ^ 16'h0F0F;
    err_budget = err_used + 3;
    model_seq(0, 3);
    wait_quiet();
    check_writes("retry_abort");
    chk_flags("retry_abort", 0, 0, 1);

    // Soft reset pulse while idle
    soft_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("soft_idle_busy", cfg_busy, 0);
    chk("soft_idle_nowrite", obs.size(), obs_rd);
    soft_n = 1'b1;
    model_seq(1, 0);
    wait_quiet();
    check_writes("soft_idle");
    chk_flags("soft_idle", 0, 1, 0);

    // Soft reset mid-sequence: outstanding write completes, then a full sequence
    cfg[5] = cfg[5] + 16'd1;
    model_seq(0, 0);
    exp_q = exp_q[0:1];
    wait_obs(2);
    soft_n = 1'b0;
    repeat (8) @(negedge clk);
    chk_flags("soft_mid_low", 0, 0, 0);
    soft_n = 1'b1;
    model_seq(1, 0);
    wait_quiet();
    check_writes("soft_mid");
    chk_flags("soft_mid", 0, 1, 0);

    // Spurious responses while idle are ignored
    spur = 1'b1;
    repeat (10) @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    chk_flags("spurious", 0, 1, 0);
    chk("spurious_nowrite", obs.size(), obs_rd);

    // Async reset while waiting on a transaction
    hold_resp = 1'b1;
    cfg[6] = cfg[6] + 16'd3;
    model_seq(0, 0);
    exp_q = exp_q[0:0];
    wait_obs(1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("reset_wait_wr_req", wr_req, 0);
    chk("reset_wait_busy", cfg_busy, 0);
    repeat (3) @(negedge clk);
    hold_resp = 1'b0;
    reset_n = 1'b1;
    measure_start(lat);
    chk("restart_latency", lat, STARTUP + 2);
    model_seq(1, 0);
    wait_quiet();
    check_writes("after_reset");
    chk_flags("after_reset", 0, 1, 0);

    chk("req_hold_stable", unstable, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
